stream_byte_unpacker: RTL and testbench

//  Input-side byte aligner for the AXI-stream compressor/decompressor path. Accepts fixed-width

---
 rtl/stream_byte_unpacker_pkg.sv | 26 ++
 rtl/stream_byte_unpacker_byte_ring_ram.sv | 49 ++++
 rtl/stream_byte_unpacker.sv | 163 ++++++++++++++++
 tb/tb_stream_byte_unpacker.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_byte_unpacker_pkg.sv
// Shared types, default geometry and keep-mask helper for the stream
// packing/unpacking byte FIFOs.
package stream_byte_unpacker_pkg;

  typedef logic [7:0] byte_t;

  localparam int DEF_IN_BYTES   = 8;
  localparam int DEF_OUT_BYTES  = 16;
  localparam int DEF_FIFO_DEPTH = 64;
  localparam int DEF_PTR_W      = $clog2(DEF_FIFO_DEPTH);
  localparam int DEF_CNT_W      = DEF_PTR_W + 1;

  localparam int MAX_KEEP_W = 64;
  localparam int KEEP_CNT_W = $clog2(MAX_KEEP_W) + 1;

  // Number of set bits in a keep mask; narrower masks are zero-extended by the caller.
  function automatic logic [KEEP_CNT_W-1:0] popcount_keep(input logic [MAX_KEEP_W-1:0] keep);
    logic [KEEP_CNT_W-1:0] total;
    total = {KEEP_CNT_W{1'b0}};
    for (int i = 0; i < MAX_KEEP_W; i++) begin
      total = total + {{(KEEP_CNT_W-1){1'b0}}, keep[i]};
    end
    return total;
  endfunction

endpackage

// File: rtl/stream_byte_unpacker_byte_ring_ram.sv
// Circular byte store: multi-byte write port at the tail, combinational
// multi-byte read window at the head. Indices wrap modulo DEPTH.
module byte_ring_ram
  import stream_byte_unpacker_pkg::*;
#(
  parameter int DEPTH    = DEF_FIFO_DEPTH,
  parameter int WR_BYTES = DEF_IN_BYTES,
  parameter int RD_BYTES = DEF_OUT_BYTES,
  localparam int PTR_W   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic [PTR_W-1:0]         wr_ptr,
  input  logic [WR_BYTES-1:0]      wr_en,
  input  logic [WR_BYTES-1:0][7:0] wr_data,
  input  logic [PTR_W-1:0]         rd_ptr,
  output logic [RD_BYTES-1:0][7:0] rd_data
);

  byte_t            mem_r  [DEPTH];
  logic [PTR_W-1:0] wr_idx_s [WR_BYTES];
  logic [PTR_W-1:0] rd_idx_s [RD_BYTES];

  // Wrapped byte addresses for both ports.
  always_comb begin
    for (int i = 0; i < WR_BYTES; i++) begin
      wr_idx_s[i] = wr_ptr + PTR_W'(i);
    end
    for (int j = 0; j < RD_BYTES; j++) begin
      rd_idx_s[j] = rd_ptr + PTR_W'(j);
    end
  end

  // Byte-masked write; storage is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WR_BYTES; i++) begin
      if (wr_en[i]) begin
        mem_r[wr_idx_s[i]] <= wr_data[i];
      end
    end
  end

  // Lookahead window read.
  always_comb begin
    for (int j = 0; j < RD_BYTES; j++) begin
      rd_data[j] = mem_r[rd_idx_s[j]];
    end
  end

endmodule

// File: rtl/stream_byte_unpacker.sv
// Byte aligner: buffers fixed-width stream beats in a byte ring and presents a
// head-aligned lookahead window from which the parser retires 0..OUT bytes per cycle.
module stream_byte_unpacker
  import stream_byte_unpacker_pkg::*;
#(
  parameter int NUM_BYTES_INPUT_WIDTH  = DEF_IN_BYTES,
  parameter int NUM_BYTES_OUTPUT_WIDTH = DEF_OUT_BYTES,
  parameter int FIFO_DEPTH             = DEF_FIFO_DEPTH
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_BYTES_INPUT_WIDTH-1:0][7:0]  s_tdata,
  input  logic [NUM_BYTES_INPUT_WIDTH-1:0]       s_tkeep,
  input  logic                                   s_tvalid,
  input  logic                                   s_tlast,
  output logic                                   s_tready,
  output logic [NUM_BYTES_OUTPUT_WIDTH-1:0][7:0] windowData,
  output logic [$clog2(FIFO_DEPTH):0]            windowBytesValid,
  output logic                                   windowLast,
  input  logic [$clog2(NUM_BYTES_OUTPUT_WIDTH):0] consumeBytes,
  output logic                                   streamDone,
  output logic                                   overrunError
);

  localparam int IN_W  = NUM_BYTES_INPUT_WIDTH;
  localparam int OUT_W = NUM_BYTES_OUTPUT_WIDTH;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic             last_seen_r;
  logic             stream_done_r;
  logic             overrun_r;

  logic [KEEP_CNT_W-1:0]   keep_cnt_s;
  logic [CNT_W-1:0]        in_bytes_s;
  logic [CNT_W-1:0]        add_s;
  logic [CNT_W-1:0]        eff_s;
  logic [CNT_W-1:0]        free_s;
  logic [CNT_W-1:0]        consume_ext_s;
  logic [CNT_W-1:0]        count_next_s;
  logic                    ready_s;
  logic                    accept_s;
  logic                    over_s;
  logic                    frame_end_s;
  logic [IN_W-1:0]         wr_en_s;
  logic [OUT_W-1:0][7:0]   ring_window_s;

  assign keep_cnt_s    = popcount_keep(MAX_KEEP_W'(s_tkeep));
  assign in_bytes_s    = CNT_W'(keep_cnt_s);
  assign consume_ext_s = CNT_W'(consumeBytes);

  // Flow control, consume clamping and next-count arithmetic.
  always_comb begin
    ready_s      = 1'b0;
    accept_s     = 1'b0;
    add_s        = {CNT_W{1'b0}};
    eff_s        = {CNT_W{1'b0}};
    over_s       = 1'b0;
    frame_end_s  = 1'b0;
    free_s       = CNT_W'(FIFO_DEPTH) - count_r;

    // Ready depends on registered state only; bytes consumed this cycle give no credit.
    if (!last_seen_r && (free_s >= CNT_W'(IN_W))) begin
      ready_s = 1'b1;
    end else begin
      ready_s = 1'b0;
    end

    accept_s = s_tvalid && ready_s;

    if (accept_s) begin
      add_s = in_bytes_s;
    end else begin
      add_s = {CNT_W{1'b0}};
    end

    if (consume_ext_s > count_r) begin
      over_s = 1'b1;
      eff_s  = count_r;
    end else begin
      over_s = 1'b0;
      eff_s  = consume_ext_s;
    end

    if (last_seen_r && (count_r == {CNT_W{1'b0}})) begin
      frame_end_s = 1'b1;
    end else begin
      frame_end_s = 1'b0;
    end

    count_next_s = count_r + add_s - eff_s;
  end

  // Keep is contiguous from bit 0, so the first in_bytes lanes are the valid ones.
  always_comb begin
    for (int i = 0; i < IN_W; i++) begin
      if (accept_s && (CNT_W'(i) < in_bytes_s)) begin
        wr_en_s[i] = 1'b1;
      end else begin
        wr_en_s[i] = 1'b0;
      end
    end
  end

  byte_ring_ram #(
    .DEPTH    (FIFO_DEPTH),
    .WR_BYTES (IN_W),
    .RD_BYTES (OUT_W)
  ) u_ring (
    .clk     (clk),
    .wr_ptr  (tail_r),
    .wr_en   (wr_en_s),
    .wr_data (s_tdata),
    .rd_ptr  (head_r),
    .rd_data (ring_window_s)
  );

  // Pointer, occupancy and frame-state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_r        <= {PTR_W{1'b0}};
      tail_r        <= {PTR_W{1'b0}};
      count_r       <= {CNT_W{1'b0}};
      last_seen_r   <= 1'b0;
      stream_done_r <= 1'b0;
      overrun_r     <= 1'b0;
    end else begin
      head_r        <= PTR_W'(head_r + eff_s);
      tail_r        <= PTR_W'(tail_r + add_s);
      count_r       <= count_next_s;
      stream_done_r <= frame_end_s;
      overrun_r     <= overrun_r | over_s;
      if (frame_end_s) begin
        last_seen_r <= 1'b0;
      end else if (accept_s && s_tlast) begin
        last_seen_r <= 1'b1;
      end else begin
        last_seen_r <= last_seen_r;
      end
    end
  end

  // Bytes beyond the held count read as zero so stale ring contents never leak out.
  always_comb begin
    for (int j = 0; j < OUT_W; j++) begin
      if (CNT_W'(j) < count_r) begin
        windowData[j] = ring_window_s[j];
      end else begin
        windowData[j] = 8'h00;
      end
    end
  end

  assign s_tready         = ready_s;
  assign windowBytesValid = count_r;
  assign windowLast       = last_seen_r;
  assign streamDone       = stream_done_r;
  assign overrunError     = overrun_r;

endmodule

// File: tb/tb_stream_byte_unpacker.sv
// Directed bench for stream_byte_unpacker: a byte-queue model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_stream_byte_unpacker;

  logic            clk = 1'b0;
  logic            reset;
  logic [7:0][7:0] s_tdata;
  logic [7:0]      s_tkeep;
  logic            s_tvalid;
  logic            s_tlast;
  logic            s_tready;
  logic [15:0][7:0] windowData;
  logic [6:0]      windowBytesValid;
  logic            windowLast;
  logic [4:0]      consumeBytes;
  logic            streamDone;
  logic            overrunError;

  int compared   = 0;
  int mismatched = 0;
  bit check_en   = 1'b0;

  always #5 clk = ~clk;

  stream_byte_unpacker dut (
    .clk              (clk),
    .reset            (reset),
    .s_tdata          (s_tdata),
    .s_tkeep          (s_tkeep),
    .s_tvalid         (s_tvalid),
    .s_tlast          (s_tlast),
    .s_tready         (s_tready),
    .windowData       (windowData),
    .windowBytesValid (windowBytesValid),
    .windowLast       (windowLast),
    .consumeBytes     (consumeBytes),
    .streamDone       (streamDone),
    .overrunError     (overrunError)
  );

  // Model: the buffered stream is simply a queue of bytes.
  logic [7:0] mq[$];
  bit m_last = 1'b0;
  bit m_done = 1'b0;
  bit m_over = 1'b0;
  bit m_acc;
  bit m_end;
  int m_eff;
  int m_n;

  function automatic bit m_ready();
    return !m_last && ((64 - mq.size()) >= 8);
  endfunction

  function automatic logic [127:0] m_window();
    logic [127:0] w;
    w = 128'h0;
    for (int i = 0; i < 16; i++) begin
      if (i < mq.size()) w[i*8 +: 8] = mq[i];
    end
    return w;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_last = 1'b0;
      m_done = 1'b0;
      m_over = 1'b0;
    end else begin
      m_end = m_last && (mq.size() == 0);
      m_acc = s_tvalid && m_ready();
      m_eff = (int'(consumeBytes) < mq.size()) ? int'(consumeBytes) : mq.size();
      if (int'(consumeBytes) > mq.size()) m_over = 1'b1;
      repeat (m_eff) void'(mq.pop_front());
      if (m_acc) begin
        m_n = $countones(s_tkeep);
        for (int i = 0; i < m_n; i++) mq.push_back(s_tdata[i]);
        if (s_tlast) m_last = 1'b1;
      end
      if (m_end) m_last = 1'b0;
      m_done = m_end;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_tready",  128'(s_tready),         128'(m_ready()));
      chk("m_count",   128'(windowBytesValid), 128'(mq.size()));
      chk("m_window",  windowData,             m_window());
      chk("m_last",    128'(windowLast),       128'(m_last));
      chk("m_done",    128'(streamDone),       128'(m_done));
      chk("m_overrun", 128'(overrunError),     128'(m_over));
    end
  end

  function automatic logic [63:0] seq(input logic [7:0] b);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = b + 8'(i);
    return r;
  endfunction

  task automatic cyc(input bit v, input logic [63:0] d, input logic [7:0] k,
                     input bit l, input int c);
    s_tvalid     = v;
    s_tdata      = d;
    s_tkeep      = k;
    s_tlast      = l;
    consumeBytes = 5'(c);
    @(posedge clk);
    #1;
    s_tvalid     = 1'b0;
    s_tkeep      = 8'h00;
    s_tlast      = 1'b0;
    consumeBytes = 5'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    s_tvalid     = 1'b0;
    s_tdata      = 64'h0;
    s_tkeep      = 8'h00;
    s_tlast      = 1'b0;
    consumeBytes = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    check_en = 1'b1;

    chk("rst_tready",  128'(s_tready),         128'd1);
    chk("rst_count",   128'(windowBytesValid), 128'd0);
    chk("rst_window",  windowData,             128'h0);
    chk("rst_done",    128'(streamDone),       128'd0);
    chk("rst_overrun", 128'(overrunError),     128'd0);

    // Two full beats, no consume.
    cyc(1'b1, seq(8'h00), 8'hFF, 1'b0, 0);
    cyc(1'b1, seq(8'h08), 8'hFF, 1'b0, 0);
    chk("t1_count",  128'(windowBytesValid), 128'd16);
    chk("t1_window", windowData, 128'h0F0E0D0C0B0A09080706050403020100);
    chk("t1_tready", 128'(s_tready), 128'd1);

    // Fill to capacity, then free one beat's worth.
    for (int j = 0; j < 6; j++) cyc(1'b1, seq(8'h10 + 8'(8 * j)), 8'hFF, 1'b0, 0);
    chk("t2_full_count",  128'(windowBytesValid), 128'd64);
    chk("t2_full_tready", 128'(s_tready), 128'd0);
    cyc(1'b1, seq(8'h70), 8'hFF, 1'b0, 0);
    chk("t2_blocked_count", 128'(windowBytesValid), 128'd64);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 8);
    chk("t2_cons_count",  128'(windowBytesValid), 128'd56);
    chk("t2_cons_tready", 128'(s_tready), 128'd1);

    // Move head/tail to 60, then push a beat that wraps the ring end.
    do_reset();
    for (int j = 0; j < 7; j++) cyc(1'b1, seq(8'h40 + 8'(8 * j)), 8'hFF, 1'b0, 0);
    cyc(1'b1, seq(8'h78), 8'h0F, 1'b0, 0);
    chk("t3_fill_count", 128'(windowBytesValid), 128'd60);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 16);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 16);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 16);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 12);
    chk("t3_empty_count",  128'(windowBytesValid), 128'd0);
    chk("t3_empty_window", windowData, 128'h0);
    cyc(1'b1, seq(8'hA0), 8'hFF, 1'b0, 0);
    chk("t3_wrap_count",  128'(windowBytesValid), 128'd8);
    chk("t3_wrap_window", windowData, 128'h0000000000000000A7A6A5A4A3A2A1A0);

    // Simultaneous accept and consume.
    cyc(1'b1, seq(8'hB0), 8'h03, 1'b0, 0);
    chk("t4_pre_count", 128'(windowBytesValid), 128'd10);
    cyc(1'b1, seq(8'hC0), 8'hFF, 1'b0, 5);
    chk("t4_count",  128'(windowBytesValid), 128'd13);
    chk("t4_window", windowData, 128'h000000C7C6C5C4C3C2C1C0B1B0A7A6A5);

    // Frame end: partial last beat, blocked follow-on beat, drain, done pulse.
    cyc(1'b1, seq(8'hD0), 8'h07, 1'b1, 0);
    chk("t5_last",   128'(windowLast), 128'd1);
    chk("t5_tready", 128'(s_tready), 128'd0);
    chk("t5_count",  128'(windowBytesValid), 128'd16);
    cyc(1'b1, seq(8'hE0), 8'hFF, 1'b0, 0);
    chk("t5_blocked_count", 128'(windowBytesValid), 128'd16);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 16);
    chk("t5_drain_done", 128'(streamDone), 128'd0);
    chk("t5_drain_last", 128'(windowLast), 128'd1);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 0);
    chk("t5_done",        128'(streamDone), 128'd1);
    chk("t5_done_tready", 128'(s_tready), 128'd1);
    chk("t5_done_last",   128'(windowLast), 128'd0);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 0);
    chk("t5_done_pulse", 128'(streamDone), 128'd0);

    // Empty tlast beat.
    cyc(1'b1, 64'h0, 8'h00, 1'b1, 0);
    chk("t5b_last",  128'(windowLast), 128'd1);
    chk("t5b_count", 128'(windowBytesValid), 128'd0);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 0);
    chk("t5b_done",  128'(streamDone), 128'd1);

    // Overrun, stickiness, then asynchronous reset mid-frame.
    cyc(1'b1, seq(8'hF0), 8'h0F, 1'b0, 0);
    chk("t6_pre_count", 128'(windowBytesValid), 128'd4);
    cyc(1'b0, 64'h0, 8'h00, 1'b0, 9);
    chk("t6_count",   128'(windowBytesValid), 128'd0);
    chk("t6_overrun", 128'(overrunError), 128'd1);
    repeat (2) cyc(1'b0, 64'h0, 8'h00, 1'b0, 0);
    chk("t6_sticky", 128'(overrunError), 128'd1);
    cyc(1'b1, seq(8'hF8), 8'hFF, 1'b0, 0);
    chk("t6_refill", 128'(windowBytesValid), 128'd8);
    #3;
    reset = 1'b1;
    #1;
    chk("t6_rst_count",   128'(windowBytesValid), 128'd0);
    chk("t6_rst_window",  windowData, 128'h0);
    chk("t6_rst_tready",  128'(s_tready), 128'd1);
    chk("t6_rst_overrun", 128'(overrunError), 128'd0);
    chk("t6_rst_done",    128'(streamDone), 128'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) cyc(1'b0, 64'h0, 8'h00, 1'b0, 0);
    chk("t6_post_done", 128'(streamDone), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
